// File: rtl/wb_adapter_pkg.sv
// wb_adapter_pkg: shared FSM type, counter width and parameter checks for wb_slave_adapter.
package wb_adapter_pkg;
  localparam int TIMEOUT_W = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } state_e;
  function automatic bit dw_legal(input int dw);
    return dw == 8 || dw == 16 || dw == 32;
  endfunction
endpackage

// File: rtl/wb_slave_adapter.sv
// wb_slave_adapter: Wishbone B4 slave front-end turning WB cycles into a req/rdy register access,
// with classic/pipelined modes, byte enables, abort on cyc drop and a request timeout.
module wb_slave_adapter
  import wb_adapter_pkg::*;
#(
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int PIPELINED = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic [AW-1:0]   wb_adr_i,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic [DW/8-1:0] wb_sel_i,
  input  logic            wb_we_i,
  input  logic            wb_stb_i,
  input  logic            wb_cyc_i,
  output logic [DW-1:0]   wb_dat_o,
  output logic            wb_ack_o,
  output logic            wb_err_o,
  output logic            wb_stall_o,
  output logic            reg_req_o,
  output logic            reg_we_o,
  output logic [AW-1:0]   reg_addr_o,
  output logic [DW-1:0]   reg_wdata_o,
  output logic [DW/8-1:0] reg_be_o,
  input  logic            reg_rdy_i,
  input  logic [DW-1:0]   reg_rdata_i,
  input  logic            reg_err_i,
  output logic            busy_o
);
  localparam int SW = DW / 8;
  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  if (!dw_legal(DW) || TIMEOUT < 0 || TIMEOUT > 255) begin : g_param_check
    $error("wb_slave_adapter: DW must be 8/16/32 and TIMEOUT 0..255");
  end

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]        be_q, be_d;
  logic                 we_q, we_d, err_q, err_d;
  logic                 accept, zero_sel, timed_out;

  assign accept    = wb_cyc_i & wb_stb_i;
  assign zero_sel  = wb_sel_i == '0;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = wb_adr_i;
        wdata_d = wb_dat_i;
        we_d    = wb_we_i;
        be_d    = (!wb_we_i && zero_sel) ? '1 : wb_sel_i;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = (wb_we_i && zero_sel) ? RESP : REQ;
      end
      REQ: begin
        cnt_d = cnt_q + TIMEOUT_W'(1);
        // a completion racing the cyc drop is simply discarded
        if (!wb_cyc_i) state_d = reg_rdy_i ? IDLE : ABORT;
        else if (reg_rdy_i) begin
          state_d = RESP;
          err_d   = reg_err_i;
          rdata_d = we_q ? rdata_q : reg_rdata_i;
        end else if (timed_out) begin
          state_d = RESP;
          err_d   = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      ABORT:   state_d = reg_rdy_i ? IDLE : ABORT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign wb_dat_o    = rdata_q;
  assign wb_ack_o    = (state_q == RESP) && !err_q && wb_cyc_i;
  assign wb_err_o    = (state_q == RESP) && err_q && wb_cyc_i;
  assign wb_stall_o  = (PIPELINED != 0) && (state_q != IDLE);
  assign reg_req_o   = (state_q == REQ) || (state_q == ABORT);
  assign reg_we_o    = we_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_be_o    = be_q;
  assign busy_o      = state_q != IDLE;
endmodule

// File: tb/tb_wb_slave_adapter.sv
// tb_wb_slave_adapter: directed bench driving a classic 8-bit and a pipelined 32-bit adapter.
module tb_wb_slave_adapter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  logic [2:0]  a_adr, a_raddr;
  logic [7:0]  a_dat, a_rdata, a_dat_o, a_rwdata;
  logic        a_sel, a_rbe, a_we, a_stb, a_cyc, a_rdy, a_rerr;
  logic        a_ack, a_err, a_stall, a_req, a_rwe, a_busy;
  logic [2:0]  b_adr, b_raddr;
  logic [31:0] b_dat, b_rdata, b_dat_o, b_rwdata;
  logic [3:0]  b_sel, b_rbe;
  logic        b_we, b_stb, b_cyc, b_rdy, b_rerr;
  logic        b_ack, b_err, b_stall, b_req, b_rwe, b_busy;

  wb_slave_adapter #(.AW(3), .DW(8), .PIPELINED(0), .TIMEOUT(16)) u_classic (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wb_adr_i(a_adr), .wb_dat_i(a_dat), .wb_sel_i(a_sel), .wb_we_i(a_we),
    .wb_stb_i(a_stb), .wb_cyc_i(a_cyc),
    .wb_dat_o(a_dat_o), .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_stall_o(a_stall),
    .reg_req_o(a_req), .reg_we_o(a_rwe), .reg_addr_o(a_raddr), .reg_wdata_o(a_rwdata),
    .reg_be_o(a_rbe), .reg_rdy_i(a_rdy), .reg_rdata_i(a_rdata), .reg_err_i(a_rerr),
    .busy_o(a_busy)
  );

  wb_slave_adapter #(.AW(3), .DW(32), .PIPELINED(1), .TIMEOUT(16)) u_pipe (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .wb_adr_i(b_adr), .wb_dat_i(b_dat), .wb_sel_i(b_sel), .wb_we_i(b_we),
    .wb_stb_i(b_stb), .wb_cyc_i(b_cyc),
    .wb_dat_o(b_dat_o), .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_stall_o(b_stall),
    .reg_req_o(b_req), .reg_we_o(b_rwe), .reg_addr_o(b_raddr), .reg_wdata_o(b_rwdata),
    .reg_be_o(b_rbe), .reg_rdy_i(b_rdy), .reg_rdata_i(b_rdata), .reg_err_i(b_rerr),
    .busy_o(b_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    {a_adr, a_dat, a_sel, a_we, a_stb, a_cyc, a_rdy, a_rerr, a_rdata} = '0;
    {b_adr, b_dat, b_sel, b_we, b_stb, b_cyc, b_rdy, b_rerr, b_rdata} = '0;
    tick();
    tick();
    check("rst_a_ctl", 32'({a_ack, a_err, a_stall, a_req, a_rwe, a_busy}), 'h0);
    check("rst_a_data", 32'({a_dat_o, a_rwdata, a_raddr, a_rbe}), 'h0);
    check("rst_b_ctl", 32'({b_ack, b_err, b_stall, b_req, b_rwe, b_busy, b_raddr, b_rbe}), 'h0);
    check("rst_b_dat", b_dat_o | b_rwdata, 'h0);
    rst_n = 1'b1;
    tick();
    // classic write, rdy in the first REQ cycle
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 3; a_dat = 8'h5A; a_sel = 1;
    tick();
    check("wr_req", 32'({a_req, a_rwe, a_raddr, a_rbe}), 32'({1'b1, 1'b1, 3'd3, 1'b1}));
    check("wr_wdata", 32'(a_rwdata), 'h5A);
    check("wr_no_early_ack", 32'({a_ack, a_err, a_stall}), 'h0);
    a_rdy = 1;
    tick();
    a_rdy = 0;
    check("wr_ack", 32'({a_ack, a_err, a_req, a_busy}), 'b1001);
    tick();
    check("wr_ack_pulse", 32'({a_ack, a_err, a_req, a_busy}), 'h0);
    // stb left high after ack: new read, sel=0 means full word
    a_we = 0; a_adr = 5; a_sel = 0;
    tick();
    check("rd0_req", 32'({a_req, a_rwe, a_raddr, a_rbe}), 32'({1'b1, 1'b0, 3'd5, 1'b1}));
    a_rdy = 1; a_rdata = 8'h3C;
    tick();
    a_rdy = 0; a_rdata = 0;
    check("rd0_ack", 32'({a_ack, a_err}), 'b10);
    check("rd0_data", 32'(a_dat_o), 'h3C);
    a_cyc = 0; a_stb = 0;
    #1;
    check("resp_cyc_drop", 32'({a_ack, a_err}), 'h0);
    tick();
    check("resp_cyc_idle", 32'({a_busy, a_req}), 'h0);
    // abort: cyc falls in the second REQ cycle, rdy arrives 4 cycles later
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 2; a_dat = 8'h99; a_sel = 1;
    tick();
    check("ab_req1", 32'(a_req), 'h1);
    tick();
    a_cyc = 0; a_stb = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("ab_hold", 32'({a_req, a_busy, a_ack, a_err}), 'b1100);
      tick();
    end
    a_rdy = 1;
    check("ab_rdy_cycle", 32'({a_req, a_busy, a_ack, a_err}), 'b1100);
    tick();
    a_rdy = 0;
    check("ab_done", 32'({a_req, a_busy, a_ack, a_err}), 'h0);
    a_cyc = 1; a_stb = 1; a_we = 0; a_adr = 1; a_sel = 1;
    tick();
    check("ab_next_req", 32'({a_req, a_raddr}), 32'({1'b1, 3'd1}));
    a_rdy = 1; a_rdata = 8'hA5;
    tick();
    a_rdy = 0; a_rdata = 0;
    check("ab_next_ack", 32'({a_ack, a_err, a_dat_o}), 32'({2'b10, 8'hA5}));
    tick();
    a_cyc = 0; a_stb = 0;
    check("ab_next_idle", 32'(a_busy), 'h0);
    // asynchronous reset in the middle of REQ
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 4; a_dat = 8'h77; a_sel = 1;
    tick();
    check("rs_req", 32'(a_req), 'h1);
    a_cyc = 0; a_stb = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rs_ctl", 32'({a_ack, a_err, a_stall, a_req, a_rwe, a_busy}), 'h0);
    check("rs_data", 32'({a_dat_o, a_rwdata, a_raddr, a_rbe}), 'h0);
    tick();
    rst_n = 1'b1;
    tick();
    // zero-select write: acked without a backend request
    a_cyc = 1; a_stb = 1; a_we = 1; a_adr = 6; a_dat = 8'h11; a_sel = 0;
    tick();
    check("zs_ack", 32'({a_ack, a_err, a_req, a_busy}), 'b1001);
    tick();
    a_cyc = 0; a_stb = 0;
    check("zs_done", 32'({a_ack, a_req, a_busy, a_dat_o}), 'h0);
    // pipelined 32-bit read with 3 wait cycles
    b_cyc = 1; b_stb = 1; b_we = 0; b_adr = 2; b_sel = 4'hF;
    check("p_idle_stall", 32'(b_stall), 'h0);
    tick();
    b_stb = 0;
    check("p_rd_req", 32'({b_raddr, b_rbe}), 32'({3'd2, 4'hF}));
    for (int i = 0; i < 3; i++) begin
      check("p_rd_wait", 32'({b_req, b_stall, b_ack, b_rwe}), 'b1100);
      tick();
    end
    b_rdy = 1; b_rdata = 32'hDEADBEEF;
    tick();
    b_rdy = 0; b_rdata = 0;
    check("p_rd_ack", 32'({b_ack, b_err, b_stall}), 'b101);
    check("p_rd_data", b_dat_o, 32'hDEADBEEF);
    tick();
    check("p_rd_idle", 32'({b_stall, b_busy, b_ack}), 'h0);
    b_stb = 1; b_we = 1; b_adr = 1; b_dat = 32'h12345678; b_sel = 4'b0011;
    tick();
    b_stb = 0;
    check("p_wr_req", 32'({b_req, b_rwe, b_raddr, b_rbe}), 32'({1'b1, 1'b1, 3'd1, 4'b0011}));
    check("p_wr_wdata", b_rwdata, 32'h12345678);
    b_rdy = 1; b_rdata = 32'hCAFEF00D;
    tick();
    b_rdy = 0; b_rdata = 0;
    check("p_wr_ack", 32'({b_ack, b_err}), 'b10);
    check("p_dat_held", b_dat_o, 32'hDEADBEEF);
    tick();
    // two queued strobes: second waits for IDLE
    b_stb = 1; b_we = 0; b_adr = 5; b_sel = 4'hF;
    tick();
    b_adr = 6;
    check("q1_req", 32'({b_req, b_stall, b_raddr}), 32'({2'b11, 3'd5}));
    b_rdy = 1; b_rdata = 32'h11112222;
    tick();
    b_rdy = 0; b_rdata = 0;
    check("q1_ack", 32'({b_ack, b_stall, b_req}), 'b110);
    check("q1_data", b_dat_o, 32'h11112222);
    tick();
    check("q_idle", 32'({b_ack, b_stall, b_req, b_busy}), 'h0);
    tick();
    b_stb = 0;
    check("q2_req", 32'({b_req, b_stall, b_raddr}), 32'({2'b11, 3'd6}));
    b_rdy = 1; b_rdata = 32'h33334444;
    tick();
    b_rdy = 0; b_rdata = 0;
    check("q2_ack", 32'({b_ack, b_err, b_stall}), 'b101);
    check("q2_data", b_dat_o, 32'h33334444);
    tick();
    // timeout with a silent backend
    b_stb = 1; b_we = 1; b_adr = 7; b_dat = 32'hA5A5A5A5; b_sel = 4'hF;
    tick();
    b_stb = 0;
    for (int i = 0; i < 16; i++) begin
      check("to_wait", 32'({b_req, b_err, b_ack}), 'b100);
      tick();
    end
    check("to_err", 32'({b_req, b_err, b_ack, b_busy}), 'b0101);
    tick();
    check("to_done", 32'({b_err, b_busy}), 'h0);
    // rdy on the last allowed REQ cycle beats the timeout
    b_stb = 1; b_we = 0; b_adr = 3;
    tick();
    b_stb = 0;
    for (int i = 0; i < 15; i++) tick();
    b_rdy = 1; b_rdata = 32'h0BADF00D;
    tick();
    b_rdy = 0; b_rdata = 0;
    check("to_rdy_wins", 32'({b_ack, b_err}), 'b10);
    check("to_rdy_data", b_dat_o, 32'h0BADF00D);
    tick();
    // backend error response
    b_stb = 1; b_we = 1; b_adr = 0;
    tick();
    b_stb = 0; b_rdy = 1; b_rerr = 1;
    tick();
    b_rdy = 0; b_rerr = 0;
    check("berr", 32'({b_ack, b_err}), 'b01);
    tick();
    b_cyc = 0;
    check("berr_idle", 32'({b_err, b_busy}), 'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/wb_slave_adapter.md
Name: wb_slave_adapter

Overview:
Parametrised Wishbone B4 slave front-end that turns WB cycles into a simple req/rdy register-access handshake for a peripheral core (UART 16550 register file first, wider cores later). It is the next step beyond the fixed 8-bit signal bundle. Data and address widths are generic, and it supports classic or pipelined (stall) mode, byte enables, an abort path and a bus-timeout error. It sits between the WB interconnect and the core register block.

Parameters:
AW, 3, address width in words.
DW, 8, data width; legal values 8, 16, 32.
SW, DW/8, byte-select width (derived, not overridable).
PIPELINED, 0, 0 = classic (stall tied 0), 1 = pipelined with wb_stall_o.
TIMEOUT, 16, cycles in REQ before error response; 0 disables; max 255.

Ports:
wb_clk_i  in  1  clock; all logic on posedge
wb_rst_i  in  1  asynchronous, active-low reset
wb_adr_i  in  AW  word address
wb_dat_i  in  DW  write data
wb_sel_i  in  SW  byte selects
wb_we_i  in  1  write enable
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_dat_o  out  DW  read data
wb_ack_o  out  1  normal termination
wb_err_o  out  1  error termination
wb_stall_o  out  1  pipelined-mode stall
reg_req_o  out  1  backend request
reg_we_o  out  1  backend write
reg_addr_o  out  AW  backend address
reg_wdata_o  out  DW  backend write data
reg_be_o  out  SW  backend byte enables
reg_rdy_i  in  1  backend completes current request
reg_rdata_i  in  DW  backend read data, valid with reg_rdy_i
reg_err_i  in  1  backend error, valid with reg_rdy_i
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset (wb_rst_i=0, async): FSM=IDLE. All outputs 0, including wb_dat_o, reg_addr_o/wdata/be and the timeout counter.
- Accept: in IDLE, wb_cyc_i & wb_stb_i sampled high. In pipelined mode wb_stall_o=0 in IDLE only. Registers adr/dat/sel/we into reg_* outputs. Goes to REQ with reg_req_o=1 on the next cycle.
- Zero-select write (we=1, sel=0): no backend access. Goes to RESP and acks the next cycle.
- Read with sel=0: treated as a full-word read.
- REQ: reg_req_o held, reg_* stable. On reg_rdy_i: capture reg_rdata_i into wb_dat_o (reads only), go to RESP with ack (err if reg_err_i).
- RESP: exactly one cycle of wb_ack_o xor wb_err_o, then IDLE. Minimum latency is stb-sample to ack = 2 cycles, with rdy in the first REQ cycle.
- Classic mode: if stb is still high in the cycle after ack, it is a new transfer and is accepted from IDLE. No back-to-back ack.
- Pipelined mode: wb_stall_o=1 in REQ, RESP and ABORT. One outstanding transfer only.
- wb_dat_o holds the last read value until the next read completes. Writes do not disturb it.
- Timeout: 8-bit counter cleared on entering REQ and incremented each REQ cycle. When count == TIMEOUT-1 without rdy, drop reg_req_o and go to RESP with wb_err_o=1. Backend must tolerate request withdrawal.
- Abort: wb_cyc_i falling while in REQ sends the FSM to ABORT. ABORT keeps reg_req_o until reg_rdy_i, then discards the response and returns to IDLE with no ack/err. cyc_i falling in RESP drops the ack that cycle and returns to IDLE.
- rdy and timeout in the same cycle: rdy wins, normal ack.
- FSM states: IDLE, REQ, RESP, ABORT; 2-bit encoding.

Decomposition:
- Package wb_adapter_pkg: fsm state enum, DW legality check function, TIMEOUT_W=8 constant.
- Single module, no sub-modules.
- The timeout counter is inline.

Test Plan:
- Classic write (DW=8), adr=3, dat=0x5A, sel=1, rdy 1 cycle after req -> reg_addr_o=3, reg_wdata_o=0x5A; ack exactly 2 cycles after stb; single-cycle pulse.
- Read (DW=32), adr=2, backend returns 0xDEADBEEF after 3 wait cycles -> wb_dat_o=0xDEADBEEF with ack; value held through a following write.
- Timeout, TIMEOUT=16, backend never rdy -> reg_req_o drops and wb_err_o pulses 17 cycles after accept; no ack.
- Abort: drop cyc_i in 2nd REQ cycle, rdy 4 cycles later -> no ack/err; busy_o low the cycle after rdy; next transfer works.
- Pipelined mode, two queued stb -> stall_o=1 from accept through ack; second transfer accepted only in IDLE; two acks; order preserved.
- Async reset mid-REQ plus zero-select write -> all outputs 0 immediately; after release, write with sel=0 acks with reg_req_o never asserted.
